// File: rtl/key_cond_pkg.sv
`default_nettype none
// ============================================================================
// Module      : key_cond_pkg
// Description : Shared types and default constants for the KEY0 conditioner.
//               Holds the debounce state encoding, the default timing and
//               counter width, and a helper that answers whether a state
//               counts as "key down".
// Revision    : 1.0 - initial release
// ============================================================================
package key_cond_pkg;

    // Debounce state machine encoding
    typedef enum logic [1:0] {
        ST_RELEASED     = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_PRESSED      = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } key_state_t;

    // Defaults for a 50 MHz fabric clock
    localparam int KC_DEBOUNCE_DEF = 1_000_000;   // 20 ms
    localparam int KC_LONG_DEF     = 50_000_000;  // 1 s
    localparam int KC_CNT_W_DEF    = 8;

    // RELEASE_WAIT still reports the key as down: the release is not yet
    // accepted, so the clean level must not move until it is.
    function automatic logic kc_is_down(input key_state_t st);
        return (st == ST_PRESSED) || (st == ST_RELEASE_WAIT);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module      : sync_2ff
// Description : Generic two-flop synchroniser for asynchronous board inputs
//               (keys, switches). The reset value is a parameter so that
//               active-low inputs can come out of reset in their idle level.
// Ports       : clk  - destination clock
//               rst  - synchronous active-high reset
//               i_d  - asynchronous input
//               o_q  - synchronised output (2 cycles of latency)
// Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic [WIDTH-1:0] i_d,
    output logic      [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/key_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : key_conditioner
// Description : Conditions the raw active-low KEY0 pin for the HPS PIO and
//               fabric logic: 2-FF synchronisation, four-state debounce,
//               single-cycle press / release / long-press strobes and a
//               wrap-around press counter.
// Ports       : clk_clk          - system clock (50 MHz)
//               reset_reset      - synchronous active-high reset
//               key_n_in         - raw KEY0 pin, 0 = pressed, asynchronous
//               key_db_n         - debounced level, 0 = pressed (to PIO)
//               pressed          - debounced level, 1 = pressed
//               press_pulse      - one-cycle strobe on accepted press
//               release_pulse    - one-cycle strobe on accepted release
//               long_press_pulse - one-cycle strobe, at most once per press
//               count_clr        - synchronous clear of press_count
//               press_count      - accepted presses modulo 2^CNT_W
// Revision    : 1.0 - initial release
// ============================================================================
module key_conditioner
    import key_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES   = KC_DEBOUNCE_DEF,
    parameter int LONG_PRESS_CYCLES = KC_LONG_DEF,
    parameter int CNT_W             = KC_CNT_W_DEF
) (
    input  wire logic             clk_clk,
    input  wire logic             reset_reset,
    input  wire logic             key_n_in,
    output logic                  key_db_n,
    output logic                  pressed,
    output logic                  press_pulse,
    output logic                  release_pulse,
    output logic                  long_press_pulse,
    input  wire logic             count_clr,
    output logic      [CNT_W-1:0] press_count
);

    // ------------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------------
    if (DEBOUNCE_CYCLES < 2) begin : g_chk_debounce
        $error("key_conditioner: DEBOUNCE_CYCLES must be >= 2");
    end
    if (LONG_PRESS_CYCLES < 1) begin : g_chk_long
        $error("key_conditioner: LONG_PRESS_CYCLES must be >= 1");
    end
    if (CNT_W < 1) begin : g_chk_cnt_w
        $error("key_conditioner: CNT_W must be >= 1");
    end

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_DB_W   = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int c_HOLD_W = (LONG_PRESS_CYCLES > 1) ? $clog2(LONG_PRESS_CYCLES + 1) : 1;

    localparam logic [c_DB_W-1:0]   c_DB_ONE    = c_DB_W'(1);
    localparam logic [c_DB_W-1:0]   c_DB_LAST   = c_DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_ONE  = c_HOLD_W'(1);
    // Hold counter parks one above the firing value so the fire compare can
    // never be true twice within the same press.
    localparam logic [c_HOLD_W-1:0] c_HOLD_FIRE = c_HOLD_W'(LONG_PRESS_CYCLES - 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_MAX  = c_HOLD_W'(LONG_PRESS_CYCLES);
    localparam logic [CNT_W-1:0]    c_CNT_ONE   = CNT_W'(1);

    // ------------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------------
    logic                w_key_s;
    key_state_t          r_state;
    key_state_t          w_state_nxt;
    logic [c_DB_W-1:0]   r_db_cnt;
    logic [c_DB_W-1:0]   w_db_cnt_nxt;
    logic [c_HOLD_W-1:0] r_hold_cnt;
    logic [c_HOLD_W-1:0] w_hold_cnt_nxt;

    logic                w_pressed_nxt;
    logic                w_press_pulse_nxt;
    logic                w_release_pulse_nxt;
    logic                w_long_pulse_nxt;

    logic                r_pressed;
    logic                r_key_db_n;
    logic                r_press_pulse;
    logic                r_release_pulse;
    logic                r_long_pulse;
    logic [CNT_W-1:0]    r_press_count;

    // ------------------------------------------------------------------------
    // Pin synchroniser; idles at 1 (released) out of reset
    // ------------------------------------------------------------------------
    sync_2ff #(
        .WIDTH     (1),
        .RESET_VAL (1'b1)
    ) u_key_sync (
        .clk (clk_clk),
        .rst (reset_reset),
        .i_d (key_n_in),
        .o_q (w_key_s)
    );

    // ------------------------------------------------------------------------
    // State register (state plus its counters)
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_state    <= ST_RELEASED;
            r_db_cnt   <= '0;
            r_hold_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_db_cnt   <= w_db_cnt_nxt;
            r_hold_cnt <= w_hold_cnt_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_db_cnt_nxt   = '0;
        w_hold_cnt_nxt = r_hold_cnt;

        case (r_state)
            ST_RELEASED: begin
                if (!w_key_s) begin
                    w_state_nxt  = ST_PRESS_WAIT;
                    w_db_cnt_nxt = c_DB_ONE;
                end
            end
            ST_PRESS_WAIT: begin
                // Zeroing here means the hold count is 0 in the press_pulse cycle
                w_hold_cnt_nxt = '0;
                if (w_key_s) begin
                    w_state_nxt = ST_RELEASED;
                end else if (r_db_cnt == c_DB_LAST) begin
                    w_state_nxt = ST_PRESSED;
                end else begin
                    w_db_cnt_nxt = r_db_cnt + c_DB_ONE;
                end
            end
            ST_PRESSED: begin
                if (w_key_s) begin
                    w_state_nxt  = ST_RELEASE_WAIT;
                    w_db_cnt_nxt = c_DB_ONE;
                end
            end
            ST_RELEASE_WAIT: begin
                if (!w_key_s) begin
                    w_state_nxt = ST_PRESSED;
                end else if (r_db_cnt == c_DB_LAST) begin
                    w_state_nxt = ST_RELEASED;
                end else begin
                    w_db_cnt_nxt = r_db_cnt + c_DB_ONE;
                end
            end
            default: begin
                w_state_nxt = ST_RELEASED;
            end
        endcase

        // Hold time keeps running through release bounce so a long press is
        // timed from the accepted press, not from the last bounce.
        if (kc_is_down(r_state) && (r_hold_cnt != c_HOLD_MAX)) begin
            w_hold_cnt_nxt = r_hold_cnt + c_HOLD_ONE;
        end
    end

    // ------------------------------------------------------------------------
    // Output decode, taken from the upcoming state so that the registered
    // outputs line up with the state register.
    // ------------------------------------------------------------------------
    always_comb begin
        w_pressed_nxt       = kc_is_down(w_state_nxt);
        w_press_pulse_nxt   = (r_state == ST_PRESS_WAIT)   && (w_state_nxt == ST_PRESSED);
        w_release_pulse_nxt = (r_state == ST_RELEASE_WAIT) && (w_state_nxt == ST_RELEASED);
        w_long_pulse_nxt    = kc_is_down(r_state) && (r_hold_cnt == c_HOLD_FIRE);
    end

    // ------------------------------------------------------------------------
    // Registered outputs and press counter
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_pressed       <= 1'b0;
            r_key_db_n      <= 1'b1;
            r_press_pulse   <= 1'b0;
            r_release_pulse <= 1'b0;
            r_long_pulse    <= 1'b0;
            r_press_count   <= '0;
        end else begin
            r_pressed       <= w_pressed_nxt;
            r_key_db_n      <= ~w_pressed_nxt;
            r_press_pulse   <= w_press_pulse_nxt;
            r_release_pulse <= w_release_pulse_nxt;
            r_long_pulse    <= w_long_pulse_nxt;
            // A clear that coincides with a press still counts that press
            if (count_clr) begin
                r_press_count <= r_press_pulse ? c_CNT_ONE : '0;
            end else if (r_press_pulse) begin
                r_press_count <= r_press_count + c_CNT_ONE;
            end
        end
    end

    assign pressed          = r_pressed;
    assign key_db_n         = r_key_db_n;
    assign press_pulse      = r_press_pulse;
    assign release_pulse    = r_release_pulse;
    assign long_press_pulse = r_long_pulse;
    assign press_count      = r_press_count;

endmodule
`default_nettype wire

// File: tb/tb_key_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : tb_key_conditioner
// Description : Self-checking bench for key_conditioner (DEBOUNCE 8, LONG 32,
//               CNT_W 4). Expected event cycles are pushed to per-event
//               queues when the pin is driven; a negedge monitor pops and
//               compares them as the pulses appear.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_key_conditioner;

    localparam int DB   = 8;
    localparam int LP   = 32;
    localparam int CW   = 4;
    localparam int LAT  = 2 + DB;   // pin edge to accepted event

    logic          clk_clk;
    logic          reset_reset;
    logic          key_n_in;
    logic          count_clr;
    logic          key_db_n;
    logic          pressed;
    logic          press_pulse;
    logic          release_pulse;
    logic          long_press_pulse;
    logic [CW-1:0] press_count;

    key_conditioner #(
        .DEBOUNCE_CYCLES   (DB),
        .LONG_PRESS_CYCLES (LP),
        .CNT_W             (CW)
    ) dut (
        .clk_clk          (clk_clk),
        .reset_reset      (reset_reset),
        .key_n_in         (key_n_in),
        .key_db_n         (key_db_n),
        .pressed          (pressed),
        .press_pulse      (press_pulse),
        .release_pulse    (release_pulse),
        .long_press_pulse (long_press_pulse),
        .count_clr        (count_clr),
        .press_count      (press_count)
    );

    initial clk_clk = 1'b0;
    always #5 clk_clk = ~clk_clk;

    int cyc = 0;
    always @(posedge clk_clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;
    int model_cnt = 0;

    int q_press[$];
    int q_release[$];
    int q_long[$];

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk_clk) begin
        if (q_press.size() > 0 && q_press[0] < cyc) chk("press_pulse missing", -1, q_press.pop_front());
        if (q_release.size() > 0 && q_release[0] < cyc) chk("release_pulse missing", -1, q_release.pop_front());
        if (q_long.size() > 0 && q_long[0] < cyc) chk("long_press_pulse missing", -1, q_long.pop_front());

        if (press_pulse) begin
            if (q_press.size() == 0) chk("press_pulse unexpected", cyc, -1);
            else                     chk("press_pulse cycle", cyc, q_press.pop_front());
            chk("pressed at press_pulse", pressed, 1);
            chk("key_db_n at press_pulse", key_db_n, 0);
        end
        if (release_pulse) begin
            if (q_release.size() == 0) chk("release_pulse unexpected", cyc, -1);
            else                       chk("release_pulse cycle", cyc, q_release.pop_front());
            chk("pressed at release_pulse", pressed, 0);
            chk("key_db_n at release_pulse", key_db_n, 1);
        end
        if (long_press_pulse) begin
            if (q_long.size() == 0) chk("long_press_pulse unexpected", cyc, -1);
            else                    chk("long_press_pulse cycle", cyc, q_long.pop_front());
        end
    end

    // ---------------- stimulus helpers ----------------
    // Called at a negedge: pin low for n_low cycles, then high for idle cycles.
    task automatic key_seq(input int n_low, input bit exp_press, input bit exp_long, input int idle);
        int s;
        s = cyc;
        key_n_in = 1'b0;
        if (exp_press) begin
            q_press.push_back(s + LAT);
            q_release.push_back(s + n_low + LAT);
            if (exp_long) q_long.push_back(s + LAT + LP);
            model_cnt = (model_cnt + 1) % (1 << CW);
        end
        repeat (n_low) @(negedge clk_clk);
        key_n_in = 1'b1;
        repeat (idle) @(negedge clk_clk);
    endtask

    typedef struct {
        int low_len;    // pin low cycles
        bit exp_press;  // press (and later release) expected
        bit exp_long;   // long-press expected
    } vec_t;

    vec_t vecs[7];

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        int e;

        vecs[0] = '{18, 1'b1, 1'b0};  // clean press: pin low 10..27 -> press 20, release 38
        vecs[1] = '{3,  1'b0, 1'b0};  // bounce
        vecs[2] = '{5,  1'b0, 1'b0};  // bounce
        vecs[3] = '{7,  1'b0, 1'b0};  // longest rejected glitch
        vecs[4] = '{8,  1'b1, 1'b0};  // shortest accepted press
        vecs[5] = '{12, 1'b1, 1'b0};
        vecs[6] = '{40, 1'b1, 1'b1};  // long press

        reset_reset = 1'b1;
        key_n_in    = 1'b1;
        count_clr   = 1'b0;
        repeat (3) @(negedge clk_clk);
        chk("reset key_db_n", key_db_n, 1);
        chk("reset pressed", pressed, 0);
        chk("reset press_pulse", press_pulse, 0);
        chk("reset release_pulse", release_pulse, 0);
        chk("reset long_press_pulse", long_press_pulse, 0);
        chk("reset press_count", press_count, 0);
        reset_reset = 1'b0;

        while (cyc != 10) @(negedge clk_clk);

        // ---------------- table-driven presses and bounces ----------------
        for (int i = 0; i < 7; i++) begin
            key_seq(vecs[i].low_len, vecs[i].exp_press, vecs[i].exp_long, 14);
            chk($sformatf("vec%0d press_count", i), press_count, model_cnt);
            chk($sformatf("vec%0d pressed idle", i), pressed, 0);
        end

        // ---------------- release bounce during long press ----------------
        s = cyc;
        key_n_in = 1'b0;
        q_press.push_back(s + LAT);
        q_long.push_back(s + LAT + LP);
        q_release.push_back(s + 52 + LAT);
        model_cnt = (model_cnt + 1) % (1 << CW);
        repeat (38) @(negedge clk_clk);   // 28 cycles past press_pulse
        key_n_in = 1'b1;
        repeat (4) @(negedge clk_clk);
        chk("glitch pressed held", pressed, 1);
        key_n_in = 1'b0;
        repeat (10) @(negedge clk_clk);
        chk("glitch pressed after", pressed, 1);
        key_n_in = 1'b1;
        repeat (14) @(negedge clk_clk);
        chk("glitch press_count", press_count, model_cnt);

        // ---------------- counter clear, wrap, clear-with-press ----------------
        count_clr = 1'b1;
        @(negedge clk_clk);
        count_clr = 1'b0;
        model_cnt = 0;
        chk("count_clr", press_count, 0);
        for (int i = 0; i < 17; i++) key_seq(10, 1'b1, 1'b0, 14);
        chk("wrap press_count", press_count, 1);

        s = cyc;
        key_n_in = 1'b0;
        q_press.push_back(s + LAT);
        q_release.push_back(s + 10 + LAT);
        repeat (10) @(negedge clk_clk);   // now in the press_pulse cycle
        key_n_in  = 1'b1;
        count_clr = 1'b1;
        @(negedge clk_clk);
        count_clr = 1'b0;
        model_cnt = 1;
        chk("clr with press", press_count, 1);
        repeat (14) @(negedge clk_clk);
        chk("clr with press settled", press_count, model_cnt);

        // ---------------- reset while pressed ----------------
        s = cyc;
        key_n_in = 1'b0;
        q_press.push_back(s + LAT);
        repeat (12) @(negedge clk_clk);
        chk("pre-reset pressed", pressed, 1);
        reset_reset = 1'b1;
        repeat (2) @(negedge clk_clk);
        e = cyc;   // last edge with reset sampled high
        chk("midreset pressed", pressed, 0);
        chk("midreset key_db_n", key_db_n, 1);
        chk("midreset press_count", press_count, 0);
        chk("midreset long_press_pulse", long_press_pulse, 0);
        reset_reset = 1'b0;
        q_press.push_back(e + 10);
        q_release.push_back(e + 20 + LAT);
        model_cnt = 1;
        repeat (20) @(negedge clk_clk);
        key_n_in = 1'b1;
        repeat (14) @(negedge clk_clk);
        chk("post-reset press_count", press_count, model_cnt);
        chk("post-reset pressed", pressed, 0);

        // ---------------- leftover expectations ----------------
        repeat (2) @(negedge clk_clk);
        chk("press queue drained", q_press.size(), 0);
        chk("release queue drained", q_release.size(), 0);
        chk("long queue drained", q_long.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
